// File: rtl/scr1_dmem_port_arb.sv
// Port-B arbiter for the dual-port TCM: round-robin between the LSU (0) and DMA/debug loader (1),
// with byte-lane conversion on the way in and aligned, zero-extended read data on the way out.
module scr1_dmem_port_arb #(
   parameter int unsigned SCR1_WIDTH = 32,
   parameter int unsigned SCR1_SIZE  = 32'h00010000,
   localparam int unsigned AW        = $clog2(SCR1_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   output logic                  ack0,
   output logic                  ack1,
   input  logic                  cmd0,
   input  logic                  cmd1,
   input  logic [1:0]            width0,
   input  logic [1:0]            width1,
   input  logic [AW-1:0]         addr0,
   input  logic [AW-1:0]         addr1,
   input  logic [SCR1_WIDTH-1:0] wdata0,
   input  logic [SCR1_WIDTH-1:0] wdata1,
   output logic                  resp0_valid,
   output logic                  resp1_valid,
   output logic                  resp0_err,
   output logic                  resp1_err,
   output logic [SCR1_WIDTH-1:0] rdata0,
   output logic [SCR1_WIDTH-1:0] rdata1,
   output logic                  mem_ren,
   output logic                  mem_wen,
   output logic [3:0]            mem_web,
   output logic [AW-3:0]         mem_addr,
   output logic [SCR1_WIDTH-1:0] mem_wdata,
   input  logic [SCR1_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] WIDTH_BYTE = 2'd0;
   localparam logic [1:0] WIDTH_HALF = 2'd1;
   localparam logic [1:0] WIDTH_WORD = 2'd2;

   logic          last_grant;
   logic          gnt0, gnt1, accept, sel;
   logic          sel_cmd;
   logic [1:0]    sel_width;
   logic [AW-1:0] sel_addr;
   logic [31:0]   sel_wdata, wdata_rep;
   logic [3:0]    web_base;
   logic          req_err, mem_go;
   logic [AW-3:0] addr_q;
   logic [31:0]   wdata_q;
   logic          pend_q, owner_q, cmd_q, err_q;
   logic [1:0]    width_q, off_q;
   logic [31:0]   rdata0_q, rdata1_q, rdata_shift, rdata_fmt;

   // Priority goes to whichever requester was not granted last.
   assign gnt0   = req0 & (~req1 | last_grant);
   assign gnt1   = req1 & (~req0 | ~last_grant);
   assign ack0   = gnt0;
   assign ack1   = gnt1;
   assign accept = gnt0 | gnt1;
   assign sel    = gnt1;

   assign sel_cmd   = sel ? cmd1   : cmd0;
   assign sel_width = sel ? width1 : width0;
   assign sel_addr  = sel ? addr1  : addr0;
   assign sel_wdata = sel ? wdata1 : wdata0;

   always_comb begin
      req_err   = 1'b0;
      web_base  = 4'b0000;
      wdata_rep = sel_wdata;
      case (sel_width)
         WIDTH_BYTE: begin
            web_base  = 4'b0001;
            wdata_rep = {4{sel_wdata[7:0]}};
         end
         WIDTH_HALF: begin
            web_base  = 4'b0011;
            wdata_rep = {2{sel_wdata[15:0]}};
            req_err   = sel_addr[0];
         end
         WIDTH_WORD: begin
            web_base  = 4'b1111;
            req_err   = |sel_addr[1:0];
         end
         default: req_err = 1'b1;
      endcase
   end

   assign mem_go    = accept & ~req_err;
   assign mem_ren   = mem_go & ~sel_cmd;
   assign mem_wen   = mem_go & sel_cmd;
   assign mem_web   = mem_wen ? (web_base << sel_addr[1:0]) : 4'b0000;
   assign mem_addr  = mem_go ? sel_addr[AW-1:2] : addr_q;
   assign mem_wdata = mem_go ? wdata_rep : wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         pend_q     <= 1'b0;
         owner_q    <= 1'b0;
         cmd_q      <= 1'b0;
         width_q    <= 2'b00;
         off_q      <= 2'b00;
         err_q      <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         pend_q   <= accept;
         rdata0_q <= rdata0;
         rdata1_q <= rdata1;
         if (accept) begin
            last_grant <= sel;
            owner_q    <= sel;
            cmd_q      <= sel_cmd;
            width_q    <= sel_width;
            off_q      <= sel_addr[1:0];
            err_q      <= req_err;
         end
         if (mem_go) begin
            addr_q  <= sel_addr[AW-1:2];
            wdata_q <= wdata_rep;
         end
      end
   end

   assign rdata_shift = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      rdata_fmt = '0;
      if (!cmd_q && !err_q) begin
         case (width_q)
            WIDTH_BYTE: rdata_fmt = {24'b0, rdata_shift[7:0]};
            WIDTH_HALF: rdata_fmt = {16'b0, rdata_shift[15:0]};
            default:    rdata_fmt = rdata_shift;
         endcase
      end
   end

   // Idle port keeps its previous read data.
   assign resp0_valid = pend_q & ~owner_q;
   assign resp1_valid = pend_q & owner_q;
   assign resp0_err   = resp0_valid & err_q;
   assign resp1_err   = resp1_valid & err_q;
   assign rdata0      = resp0_valid ? rdata_fmt : rdata0_q;
   assign rdata1      = resp1_valid ? rdata_fmt : rdata1_q;

endmodule
